// File: rtl/fifo_read_serializer_pkg.sv
// Shared defaults for the FIFO read serializer: entry and beat widths used when
// the instantiating level does not override them.
package fifo_read_serializer_pkg;

   localparam int DEFAULT_IN_WIDTH  = 64;
   localparam int DEFAULT_OUT_WIDTH = 16;

endpackage

// File: rtl/fifo_read_serializer_if.sv
// Upstream FIFO read port plus narrow valid/ready output stream of the serializer.
// master is the serializer side, slave is the FIFO/consumer side.
interface fifo_read_serializer_if
   import fifo_read_serializer_pkg::*;
#(
   parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
   parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) ();

   logic                 fifo_empty;
   logic [IN_WIDTH-1:0]  fifo_value;
   logic                 fifo_dequeue_en;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;

   modport master (
      input  fifo_empty,
      input  fifo_value,
      input  out_ready,
      output fifo_dequeue_en,
      output out_valid,
      output out_data,
      output out_last
   );

   modport slave (
      output fifo_empty,
      output fifo_value,
      output out_ready,
      input  fifo_dequeue_en,
      input  out_valid,
      input  out_data,
      input  out_last
   );

endinterface

// File: rtl/fifo_read_serializer.sv
// Pops wide entries from a show-ahead FIFO and streams each one out as RATIO
// narrow beats, least significant slice first, with no bubble between entries.
module fifo_read_serializer
   import fifo_read_serializer_pkg::*;
#(
   parameter int IN_WIDTH  = DEFAULT_IN_WIDTH,
   parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   flush_en,
   output logic                   busy,
   fifo_read_serializer_if.master bus
);

   localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
   localparam int BEAT_W = $clog2(RATIO);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   state_t              next_state;
   logic [IN_WIDTH-1:0] hold;
   logic [BEAT_W-1:0]   beat;
   logic                accept;
   logic                last_beat;
   logic                done;
   logic                dequeue;

   assign accept    = bus.out_valid && bus.out_ready;
   assign last_beat = (beat == LAST_BEAT);
   assign done      = accept && last_beat;

   // Reload on the final accept keeps the stream gap-free; the reset_n term
   // keeps the upstream FIFO untouched while the block is held in reset.
   always_comb begin
      next_state = state;
      dequeue    = reset_n && !flush_en && !bus.fifo_empty && (state == IDLE || done);
      if (flush_en) begin
         next_state = IDLE;
      end else if (dequeue) begin
         next_state = SEND;
      end else if (done) begin
         next_state = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Beat returns to zero after a completed entry so out_last stays clear in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold <= '0;
         beat <= '0;
      end else if (flush_en) begin
         beat <= '0;
      end else if (dequeue) begin
         hold <= bus.fifo_value;
         beat <= '0;
      end else if (done) begin
         beat <= '0;
      end else if (accept) begin
         beat <= beat + BEAT_W'(1);
      end
   end

   assign bus.fifo_dequeue_en = dequeue;
   assign bus.out_valid       = (state == SEND);
   assign bus.out_last        = (state == SEND) && last_beat;
   assign bus.out_data        = hold[int'(beat) * OUT_WIDTH +: OUT_WIDTH];
   assign busy                = (state == SEND);

   // A stalled beat must not change or vanish unless a flush discards it.
   a_no_pop_when_empty: assert property (
      @(posedge clk) disable iff (!reset_n)
      !(bus.fifo_dequeue_en && bus.fifo_empty));

   a_stall_stable: assert property (
      @(posedge clk) disable iff (!reset_n)
      (bus.out_valid && !bus.out_ready && !flush_en) |=> (bus.out_valid && $stable(bus.out_data)));

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Bench for fifo_read_serializer: a 4-deep show-ahead FIFO model feeds the DUT and
// a scoreboard of expected beats is checked by an independent output monitor.
module tb_fifo_read_serializer;
   import fifo_read_serializer_pkg::*;

   localparam int IN_W      = 64;
   localparam int OUT_W     = 16;
   localparam int RATIO     = IN_W / OUT_W;
   localparam int FIFO_SIZE = 4;

   typedef struct packed {
      logic [OUT_W-1:0] data;
      logic             last;
   } beat_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush_en = 1'b0;
   logic busy;
   logic outReady = 1'b0;
   logic pushEn = 1'b0;
   logic [IN_W-1:0] pushData = '0;

   int checks = 0;
   int errors = 0;
   int popCount = 0;
   beat_t sbQueue[$];

   always #5 clk = ~clk;

   fifo_read_serializer_if #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) bus ();

   fifo_read_serializer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_en(flush_en),
      .busy    (busy),
      .bus     (bus)
   );

   // Upstream show-ahead FIFO: head entry is visible whenever it is non-empty.
   logic [IN_W-1:0] fifoMem [FIFO_SIZE];
   logic [1:0]      fifoRd;
   logic [1:0]      fifoWr;
   logic [2:0]      fifoCount;
   wire fifoPop  = bus.fifo_dequeue_en && (fifoCount != 3'd0);
   wire fifoPush = pushEn && (fifoCount != 3'd4);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifoRd    <= 2'd0;
         fifoWr    <= 2'd0;
         fifoCount <= 3'd0;
      end else begin
         if (fifoPop) begin
            fifoRd   <= fifoRd + 2'd1;
            popCount <= popCount + 1;
         end
         if (fifoPush) begin
            fifoMem[fifoWr] <= pushData;
            fifoWr          <= fifoWr + 2'd1;
         end
         fifoCount <= fifoCount + 3'(fifoPush) - 3'(fifoPop);
      end
   end

   assign bus.fifo_empty = (fifoCount == 3'd0);
   assign bus.fifo_value = fifoMem[fifoRd];
   assign bus.out_ready  = outReady;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs from just after a rising edge; an accepted push
   // queues the entry's beats, low slice first, in the scoreboard.
   task automatic applyStimulus(input bit doPush, input logic [IN_W-1:0] data, input bit ready, input bit flush);
      outReady = ready;
      flush_en = flush;
      if (doPush && fifoCount < 3'(FIFO_SIZE)) begin
         pushEn   = 1'b1;
         pushData = data;
         for (int i = 0; i < RATIO; i++) begin
            sbQueue.push_back('{data: data[i*OUT_W +: OUT_W], last: (i == RATIO - 1)});
         end
      end
      @(posedge clk);
      #1;
      pushEn   = 1'b0;
      flush_en = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int waited = 0;
      outReady = 1'b1;
      while ((sbQueue.size() != 0 || bus.out_valid) && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput(name, 64'(sbQueue.size()), 64'd0);
   endtask

   task automatic measureValidRun(input string name, input int expected);
      int waited = 0;
      int run = 0;
      @(negedge clk);
      while (!bus.out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      while (bus.out_valid && run < 50) begin
         run++;
         @(negedge clk);
      end
      checkOutput(name, 64'(run), 64'(expected));
      @(posedge clk);
      #1;
   endtask

   // Output monitor: every accepted beat is compared with the scoreboard head; a
   // flush discards whatever the in-flight entry had not yet delivered.
   logic             stallPending = 1'b0;
   logic [OUT_W-1:0] stallData = '0;

   always @(negedge clk) begin
      if (reset_n) begin
         beat_t exp;
         bit    accepted;
         bit    poppedLast;
         accepted   = 1'b0;
         poppedLast = 1'b0;
         if (bus.fifo_empty) checkOutput("dequeue_while_empty", 64'(bus.fifo_dequeue_en), 64'd0);
         if (stallPending) begin
            checkOutput("stall_hold_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("stall_hold_data", 64'(bus.out_data), 64'(stallData));
         end
         if (bus.out_valid && bus.out_ready) begin
            accepted = 1'b1;
            if (sbQueue.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_beat: got data %0h with nothing expected", bus.out_data);
            end else begin
               exp = sbQueue.pop_front();
               poppedLast = exp.last;
               checkOutput("beat_data", 64'(bus.out_data), 64'(exp.data));
               checkOutput("beat_last", 64'(bus.out_last), 64'(exp.last));
            end
         end
         if (flush_en && bus.out_valid && !(accepted && poppedLast)) begin
            while (sbQueue.size() != 0) begin
               exp = sbQueue.pop_front();
               if (exp.last) break;
            end
         end
         stallPending = bus.out_valid && !bus.out_ready && !flush_en;
         stallData    = bus.out_data;
      end else begin
         stallPending = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [IN_W-1:0] entryA;
      logic [IN_W-1:0] entryB;
      int popsBefore;
      int waited;
      bit found;

      // Reset state
      #12;
      checkOutput("reset_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_last", 64'(bus.out_last), 64'd0);
      checkOutput("reset_data", 64'(bus.out_data), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single entry");
      applyStimulus(1'b1, 64'h4444_3333_2222_1111, 1'b1, 1'b0);
      measureValidRun("t1_valid_run", RATIO);
      checkOutput("t1_sb_empty", 64'(sbQueue.size()), 64'd0);

      $display("[TB] back-to-back entries");
      applyStimulus(1'b1, 64'h8888_7777_6666_5555, 1'b1, 1'b0);
      applyStimulus(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 1'b1, 1'b0);
      measureValidRun("t2_valid_run", 2 * RATIO);
      checkOutput("t2_sb_empty", 64'(sbQueue.size()), 64'd0);

      $display("[TB] stalling consumer");
      popsBefore = popCount;
      applyStimulus(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
      applyStimulus(1'b1, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, '0, (i % 4 == 0) || (i % 4 == 3), 1'b0);
      end
      waitDrain("t3_drain");
      checkOutput("t3_pops_per_entry", 64'(popCount - popsBefore), 64'd2);

      $display("[TB] flush mid-entry");
      entryA = 64'hA003_A002_A001_A000;
      entryB = 64'hB003_B002_B001_B000;
      applyStimulus(1'b1, entryA, 1'b1, 1'b0);
      applyStimulus(1'b1, entryB, 1'b1, 1'b0);
      found = 1'b0;
      waited = 0;
      while (!found && waited < 20) begin
         if (bus.out_valid && bus.out_data == entryA[2*OUT_W +: OUT_W]) begin
            found = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            waited++;
         end
      end
      checkOutput("t4_reached_beat2", 64'(found), 64'd1);
      flush_en = 1'b1;
      #1;
      checkOutput("t4_no_pop_on_flush", 64'(bus.fifo_dequeue_en), 64'd0);
      @(posedge clk);
      #1;
      flush_en = 1'b0;
      checkOutput("t4_valid_drops", 64'(bus.out_valid), 64'd0);
      waitDrain("t4_drain");

      $display("[TB] reset mid-entry");
      entryA = 64'hC3C3_C2C2_C1C1_C0C0;
      applyStimulus(1'b1, entryA, 1'b1, 1'b0);
      found = 1'b0;
      waited = 0;
      while (!found && waited < 20) begin
         if (bus.out_valid && bus.out_data == entryA[OUT_W +: OUT_W]) begin
            found = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            waited++;
         end
      end
      checkOutput("t5_reached_beat1", 64'(found), 64'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("t5_async_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("t5_async_data", 64'(bus.out_data), 64'd0);
      checkOutput("t5_async_last", 64'(bus.out_last), 64'd0);
      checkOutput("t5_async_busy", 64'(busy), 64'd0);
      checkOutput("t5_async_dequeue", 64'(bus.fifo_dequeue_en), 64'd0);
      sbQueue.delete();
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("t5_idle_after_reset", 64'(bus.out_valid), 64'd0);
      end
      applyStimulus(1'b1, 64'h5A5A_A5A5_0F0F_F0F0, 1'b1, 1'b0);
      waitDrain("t5_drain");

      $display("[TB] empty fifo");
      outReady = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("t6_dequeue", 64'(bus.fifo_dequeue_en), 64'd0);
         checkOutput("t6_valid", 64'(bus.out_valid), 64'd0);
         checkOutput("t6_busy", 64'(busy), 64'd0);
      end
      @(posedge clk);
      #1;

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 2) == 0, {$urandom, $urandom}, ($urandom % 4) != 0, ($urandom % 50) == 0);
      end
      waitDrain("random_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
